// File: rtl/pio_handshake_bridge.sv
// rtl/pio_handshake_bridge.sv - hardware endpoint of the PIO mailbox with four-phase handshakes and RX/TX FIFOs

module pio_hs_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             full,
    output logic [CW-1:0]    count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    mem_count;
    logic             head_valid;
    logic [WIDTH-1:0] head_data;
    logic             push;
    logic             pop;
    logic             load;

    // Occupancy counts the head register too, so full/empty reflect every stored word.
    assign count    = mem_count + {{(CW-1){1'b0}}, head_valid};
    assign full     = (count == FULL_C);
    assign push     = wr_en && !full;
    assign pop      = rd_en && head_valid;
    assign load     = (mem_count != '0) && (!head_valid || pop);
    assign rd_data  = head_data;
    assign rd_valid = head_valid;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            mem_count  <= '0;
            head_valid <= 1'b0;
            head_data  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (load) begin
                head_data <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + PW'(1);
            end
            case ({push, load})
                2'b10:   mem_count <= mem_count + CW'(1);
                2'b01:   mem_count <= mem_count - CW'(1);
                default: mem_count <= mem_count;
            endcase
            if (load) begin
                head_valid <= 1'b1;
            end else if (pop) begin
                head_valid <= 1'b0;
            end
        end
    end
endmodule

module pio_handshake_bridge #(
    parameter int DEPTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [15:0] to_hw_port_export,
    input  logic [7:0]  to_hw_sig_export,
    output logic [15:0] to_sw_port_export,
    output logic [7:0]  to_sw_sig_export,
    output logic [15:0] rx_data,
    output logic [5:0]  rx_cmd,
    output logic        rx_valid,
    input  logic        rx_ready,
    input  logic [15:0] tx_data,
    input  logic        tx_valid,
    output logic        tx_ready
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    typedef enum logic {RX_IDLE, RX_ACK} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_VALID, TX_WAIT} tx_state_t;

    logic [7:0]  sync_q [SYNC_STAGES];
    logic [7:0]  s_sig;
    logic        s_req;
    logic        s_ack;
    logic [5:0]  s_cmd;
    rx_state_t   rx_state, rx_next;
    tx_state_t   tx_state, tx_next;
    logic        rx_push;
    logic        tx_pop;
    logic        hw_ack;
    logic        hw_valid;
    logic        rx_full;
    logic [CW-1:0] rx_count;
    logic [21:0] rx_head;
    logic        tx_full;
    logic [CW-1:0] tx_count;
    logic [15:0] tx_head;
    logic        tx_head_valid;
    logic [15:0] port_q;
    logic        rx_full_q;
    logic        tx_empty_q;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= to_hw_sig_export;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign s_sig = sync_q[SYNC_STAGES-1];
    assign s_req = s_sig[0];
    assign s_ack = s_sig[1];
    assign s_cmd = s_sig[7:2];

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            rx_state <= RX_IDLE;
            tx_state <= TX_IDLE;
        end else begin
            rx_state <= rx_next;
            tx_state <= tx_next;
        end
    end

    // Only the pin data is sampled raw; it is stable for as long as sw_req is high.
    always_comb begin
        rx_next = rx_state;
        rx_push = 1'b0;
        case (rx_state)
            RX_IDLE: if (s_req && !rx_full) begin
                rx_push = 1'b1;
                rx_next = RX_ACK;
            end
            RX_ACK:  if (!s_req) rx_next = RX_IDLE;
            default: rx_next = RX_IDLE;
        endcase

        tx_next = tx_state;
        tx_pop  = 1'b0;
        case (tx_state)
            TX_IDLE: if (tx_head_valid && !s_ack) begin
                tx_pop  = 1'b1;
                tx_next = TX_VALID;
            end
            TX_VALID: if (s_ack)  tx_next = TX_WAIT;
            TX_WAIT:  if (!s_ack) tx_next = TX_IDLE;
            default:  tx_next = TX_IDLE;
        endcase
    end

    always_comb begin
        hw_ack   = (rx_state == RX_ACK);
        hw_valid = (tx_state == TX_VALID);
    end

    pio_hs_fifo #(.DEPTH(DEPTH), .WIDTH(22)) u_rx_fifo (
        .clk      (clk_clk),
        .rst_n    (reset_reset_n),
        .wr_data  ({s_cmd, to_hw_port_export}),
        .wr_en    (rx_push),
        .rd_en    (rx_ready),
        .rd_data  (rx_head),
        .rd_valid (rx_valid),
        .full     (rx_full),
        .count    (rx_count)
    );

    pio_hs_fifo #(.DEPTH(DEPTH), .WIDTH(16)) u_tx_fifo (
        .clk      (clk_clk),
        .rst_n    (reset_reset_n),
        .wr_data  (tx_data),
        .wr_en    (tx_valid),
        .rd_en    (tx_pop),
        .rd_data  (tx_head),
        .rd_valid (tx_head_valid),
        .full     (tx_full),
        .count    (tx_count)
    );

    // Status bits deliberately lag the counts by one cycle.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            port_q     <= '0;
            rx_full_q  <= 1'b0;
            tx_empty_q <= 1'b1;
        end else begin
            if (tx_pop) begin
                port_q <= tx_head;
            end
            rx_full_q  <= (rx_count == FULL_C);
            tx_empty_q <= (tx_count == '0);
        end
    end

    assign rx_data           = rx_head[15:0];
    assign rx_cmd            = rx_head[21:16];
    assign tx_ready          = !tx_full;
    assign to_sw_port_export = port_q;
    assign to_sw_sig_export  = {4'b0000, tx_empty_q, rx_full_q, hw_valid, hw_ack};
endmodule
